// File: rtl/counter_enable_scheduler.sv
// Paces queued tick requests into single-cycle enable pulses for a downstream counter
// and double-buffers its period. Optional strobe counter: define CES_STROBE_COUNT_EN.
module counter_enable_scheduler #(
    parameter int WIDTH          = 4,
    parameter int PEND_WIDTH     = 4,
    parameter int DEFAULT_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_in,
    input  logic                  cnt_ready,
    input  logic                  cnt_strobe,
    input  logic [WIDTH-1:0]      period_in,
    input  logic                  period_valid,
    output logic                  period_ready,
    output logic                  enable,
    output logic [WIDTH-1:0]      reset_value,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  overflow,
    output logic [15:0]           strobe_count
);

    localparam logic [WIDTH-1:0]      MIN_PERIOD = WIDTH'(2);
    localparam logic [WIDTH-1:0]      RST_PERIOD = WIDTH'((DEFAULT_PERIOD < 2) ? 2 : DEFAULT_PERIOD);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t                state_q;
    logic                  enable_q;
    logic                  post_rst_q;
    logic [PEND_WIDTH-1:0] pending_q, pending_d;
    logic                  overflow_q, overflow_d;
    logic [WIDTH-1:0]      shadow_q, shadow_d;
    logic                  shadow_full_q, shadow_full_d;
    logic [WIDTH-1:0]      reset_value_q, reset_value_d;
    logic                  tick_drop, tick_take;
    logic                  accept, apply;

    always_comb begin
        tick_drop = tick_in && (pending_q == PEND_MAX) && !enable_q;
        tick_take = tick_in && !tick_drop;
        pending_d = pending_q;
        case ({tick_take, enable_q})
            2'b10:   pending_d = pending_q + PEND_WIDTH'(1);
            2'b01:   pending_d = pending_q - PEND_WIDTH'(1);
            default: pending_d = pending_q;
        endcase
        overflow_d = overflow_q | tick_drop;
    end

    // Accept needs an empty shadow and apply needs a full one, so they never coincide.
    always_comb begin
        accept        = period_valid && !shadow_full_q;
        apply         = cnt_strobe && !enable_q && shadow_full_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        reset_value_d = reset_value_q;
        if (apply) begin
            reset_value_d = shadow_q;
            shadow_full_d = 1'b0;
        end else if (accept) begin
            shadow_d      = (period_in < MIN_PERIOD) ? MIN_PERIOD : period_in;
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            enable_q   <= 1'b0;
            post_rst_q <= 1'b1;
        end else begin
            post_rst_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    enable_q <= 1'b0;
                    if (pending_d != '0) state_q <= WAIT;
                end
                WAIT: begin
                    if ((pending_q != '0) && cnt_ready && !post_rst_q) begin
                        state_q  <= PULSE;
                        enable_q <= 1'b1;
                    end
                end
                PULSE: begin
                    enable_q <= 1'b0;
                    state_q  <= (pending_d != '0) ? WAIT : IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    enable_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= '0;
            overflow_q    <= 1'b0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            reset_value_q <= RST_PERIOD;
        end else begin
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            reset_value_q <= reset_value_d;
        end
    end

`ifdef CES_STROBE_COUNT_EN
    logic [15:0] strobe_count_q, strobe_count_d;

    always_comb begin
        strobe_count_d = strobe_count_q + {15'd0, cnt_strobe};
    end

    always_ff @(posedge clk) begin
        if (rst) strobe_count_q <= '0;
        else     strobe_count_q <= strobe_count_d;
    end

    assign strobe_count = strobe_count_q;
`else
    assign strobe_count = 16'd0;
`endif

    assign period_ready = !shadow_full_q && !rst;
    assign enable       = enable_q;
    assign reset_value  = reset_value_q;
    assign pending      = pending_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_counter_enable_scheduler.sv
// Randomized + directed bench for counter_enable_scheduler against a queue-count reference model.
module tb_counter_enable_scheduler;

    localparam int PMAX = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_in = 1'b0, cnt_ready = 1'b0, cnt_strobe = 1'b0, period_valid = 1'b0;
    logic [3:0]  period_in = 4'd0;
    logic        period_ready, enable, overflow;
    logic [3:0]  reset_value, pending;
    logic [15:0] strobe_count;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_pend, m_ovf, m_en, m_full, m_shadow, m_rv, m_sc, m_since;
    int prev_en = 0;

    counter_enable_scheduler #(.WIDTH(4), .PEND_WIDTH(4), .DEFAULT_PERIOD(2)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .cnt_ready(cnt_ready),
        .cnt_strobe(cnt_strobe), .period_in(period_in), .period_valid(period_valid),
        .period_ready(period_ready), .enable(enable), .reset_value(reset_value),
        .pending(pending), .overflow(overflow), .strobe_count(strobe_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit tk, input bit rdy, input bit strb,
                                input bit pv, input int pin);
        bit nen, drop;
        if (r) begin
            m_pend = 0; m_ovf = 0; m_en = 0; m_full = 0; m_shadow = 0;
            m_rv = 2; m_sc = 0; m_since = 0;
        end else begin
            nen  = (m_pend > 0) && (m_en == 0) && rdy && (m_since > 0);
            drop = tk && (m_pend == PMAX) && (m_en == 0);
            if (tk && !drop) m_pend++;
            if (m_en != 0)   m_pend--;
            if (drop)        m_ovf = 1;
            if (m_full != 0 && strb && m_en == 0) begin
                m_rv = m_shadow; m_full = 0;
            end else if (pv && m_full == 0) begin
                m_shadow = (pin < 2) ? 2 : pin; m_full = 1;
            end
`ifdef CES_STROBE_COUNT_EN
            if (strb) m_sc = (m_sc + 1) & 16'hFFFF;
`endif
            m_en = nen ? 1 : 0;
            if (m_since < 2) m_since++;
        end
    endtask

    // one clock: drive, advance model on the edge, compare on the falling edge
    task automatic step(input bit r, input bit tk, input bit rdy, input bit strb,
                        input bit pv, input int pin);
        rst = r; tick_in = tk; cnt_ready = rdy; cnt_strobe = strb;
        period_valid = pv; period_in = 4'(pin);
        @(posedge clk);
        model_update(r, tk, rdy, strb, pv, pin);
        @(negedge clk);
        chk("enable", {31'd0, enable}, m_en);
        chk("pending", {28'd0, pending}, m_pend);
        chk("overflow", {31'd0, overflow}, m_ovf);
        chk("reset_value", {28'd0, reset_value}, m_rv);
        chk("period_ready", {31'd0, period_ready}, (m_full == 0 && !r) ? 1 : 0);
        chk("strobe_count", {16'd0, strobe_count}, m_sc);
        chk("no_back_to_back", {31'd0, enable && (prev_en != 0)}, 0);
        prev_en = enable ? 1 : 0;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, rdy, 0, 0, 0);
    endtask

    initial begin
        int n_en;
        // reset held two cycles
        step(1, 1, 1, 0, 1, 7);
        step(1, 1, 1, 0, 1, 7);
        chk("rst_enable", {31'd0, enable}, 0);
        chk("rst_pending", {28'd0, pending}, 0);
        chk("rst_reset_value", {28'd0, reset_value}, 2);
        chk("rst_period_ready", {31'd0, period_ready}, 0);

        // single tick, enable exactly two cycles later
        step(0, 1, 1, 0, 0, 0);
        chk("lat_c1_en", {31'd0, enable}, 0);
        chk("lat_c1_pend", {28'd0, pending}, 1);
        idle(1);
        chk("lat_c2_en", {31'd0, enable}, 1);
        idle(1);
        chk("lat_c3_en", {31'd0, enable}, 0);
        chk("lat_c3_pend", {28'd0, pending}, 0);

        // saturate the pending counter with the downstream stalled
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0, 0);
        chk("sat15_ovf", {31'd0, overflow}, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("sat16_pend", {28'd0, pending}, 15);
        chk("sat16_ovf", {31'd0, overflow}, 1);
        n_en = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (enable) n_en++;
        end
        chk("drain_count", n_en, 15);
        chk("drain_ovf", {31'd0, overflow}, 1);
        chk("drain_pend", {28'd0, pending}, 0);

        // tick coincident with enable keeps pending; reset mid-pulse clears everything
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        idle(1);
        chk("coinc_en", {31'd0, enable}, 1);
        step(0, 1, 0, 0, 1, 9);
        chk("coinc_pend", {28'd0, pending}, 3);
        idle(1);
        chk("pulse_before_rst", {31'd0, enable}, 1);
        step(1, 1, 1, 1, 1, 5);
        chk("rstp_en", {31'd0, enable}, 0);
        chk("rstp_pend", {28'd0, pending}, 0);
        chk("rstp_rv", {28'd0, reset_value}, 2);
        step(0, 0, 0, 1, 0, 0);
        chk("shadow_discarded", {28'd0, reset_value}, 2);
        chk("shadow_discarded_pr", {31'd0, period_ready}, 1);

        // period handshake and apply on strobe
        step(0, 0, 0, 0, 1, 7);
        chk("p7_ready", {31'd0, period_ready}, 0);
        for (int i = 0; i < 3; i++) idle(0);
        chk("p7_hold", {28'd0, reset_value}, 2);
        step(0, 0, 0, 1, 0, 0);
        chk("p7_applied", {28'd0, reset_value}, 7);
        chk("p7_ready_again", {31'd0, period_ready}, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("p0_clamped", {28'd0, reset_value}, 2);
        step(0, 0, 0, 0, 1, 15);
        step(0, 0, 0, 1, 0, 0);
        chk("p15", {28'd0, reset_value}, 15);

        // strobe during enable defers application
        step(0, 0, 0, 0, 1, 5);
        step(0, 1, 1, 0, 0, 0);
        idle(1);
        chk("defer_en", {31'd0, enable}, 1);
        step(0, 0, 0, 1, 0, 0);
        chk("defer_hold", {28'd0, reset_value}, 15);
        step(0, 0, 0, 1, 0, 0);
        chk("defer_apply", {28'd0, reset_value}, 5);

        // strobe counter
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);
`ifdef CES_STROBE_COUNT_EN
        chk("strobe5", {16'd0, strobe_count}, 5);
`else
        chk("strobe5", {16'd0, strobe_count}, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 35), int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
